// File: rtl/fp_add_sched.sv
// Round-robin sequencer sharing one combinational fp adder among N_REQ requesters.
// Optional per-requester sticky overflow/underflow flags: define FP_ADD_SCHED_STICKY_EN.
module fp_add_sched #(
    parameter int N_REQ = 2,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    input  logic [3*N_REQ-1:0]  req_rmode,
    output logic [N_REQ-1:0]    rsp_valid,
    input  logic [N_REQ-1:0]    rsp_ready,
    output logic [31:0]         rsp_result,
    output logic                rsp_overflow,
    output logic                rsp_underflow,
    output logic [31:0]         add_a,
    output logic [31:0]         add_b,
    output logic [2:0]          add_rmode,
    input  logic [31:0]         add_result,
    input  logic                add_overflow,
    input  logic                add_underflow,
    output logic                busy
`ifdef FP_ADD_SCHED_STICKY_EN
    ,
    input  logic [N_REQ-1:0]    sticky_clr,
    output logic [N_REQ-1:0]    sticky_ovf,
    output logic [N_REQ-1:0]    sticky_unf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] rr_ptr, owner;
    logic [PTR_W-1:0] grant, next_ptr;
    logic [PTR_W:0]   idx;
    logic             grant_found;
    logic             accept;
    logic [31:0]      sel_a, sel_b;
    logic [2:0]       sel_rmode, rmode_c;
    logic [N_REQ-1:0] owner_oh, grant_oh;

    // Downward scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N_REQ))
                idx = idx - (PTR_W+1)'(N_REQ);
            if (req_valid[idx[PTR_W-1:0]]) begin
                grant       = idx[PTR_W-1:0];
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_rmode = '0;
        grant_oh  = '0;
        owner_oh  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant_oh[i] = (grant == PTR_W'(i));
            owner_oh[i] = (owner == PTR_W'(i));
            if (grant == PTR_W'(i)) begin
                sel_a     = req_a[32*i +: 32];
                sel_b     = req_b[32*i +: 32];
                sel_rmode = req_rmode[3*i +: 3];
            end
        end
    end

    // Reserved rounding encodings fall back to round-to-nearest-even.
    assign rmode_c  = (sel_rmode > 3'd4) ? 3'd0 : sel_rmode;
    assign next_ptr = (grant == PTR_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    accept    = 1'b1;
                    req_ready = grant_oh;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rsp_valid = owner_oh;
                if (rsp_ready[owner])
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr        <= '0;
            owner         <= '0;
            add_a         <= '0;
            add_b         <= '0;
            add_rmode     <= '0;
            rsp_result    <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
        end else begin
            if (accept) begin
                add_a     <= sel_a;
                add_b     <= sel_b;
                add_rmode <= rmode_c;
                owner     <= grant;
                rr_ptr    <= next_ptr;
            end
            if (state == EXEC) begin
                rsp_result    <= add_result;
                rsp_overflow  <= add_overflow;
                rsp_underflow <= add_underflow;
            end
        end
    end

`ifdef FP_ADD_SCHED_STICKY_EN
    logic [N_REQ-1:0] set_ovf, set_unf;

    assign set_ovf = (state == EXEC && add_overflow)  ? owner_oh : '0;
    assign set_unf = (state == EXEC && add_underflow) ? owner_oh : '0;

    // Set takes priority over a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= '0;
            sticky_unf <= '0;
        end else begin
            sticky_ovf <= (sticky_ovf & ~sticky_clr) | set_ovf;
            sticky_unf <= (sticky_unf & ~sticky_clr) | set_unf;
        end
    end
`endif

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched with a stub adder; covers arbitration, backpressure,
// reset mid-operation and (with FP_ADD_SCHED_STICKY_EN) the sticky flags.
module tb_fp_add_sched;
    localparam int N_REQ = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*N_REQ-1:0] req_a, req_b;
    logic [3*N_REQ-1:0]  req_rmode;
    logic [31:0]         rsp_result, add_a, add_b, add_result;
    logic                rsp_overflow, rsp_underflow, add_overflow, add_underflow, busy;
    logic [2:0]          add_rmode;
`ifdef FP_ADD_SCHED_STICKY_EN
    logic [N_REQ-1:0]    sticky_clr, sticky_ovf, sticky_unf;
`endif

    int n_vec = 0;
    int miscompares = 0;

    fp_add_sched #(.N_REQ(N_REQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rmode(req_rmode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
        .add_a(add_a), .add_b(add_b), .add_rmode(add_rmode),
        .add_result(add_result), .add_overflow(add_overflow), .add_underflow(add_underflow),
        .busy(busy)
`ifdef FP_ADD_SCHED_STICKY_EN
        , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf)
`endif
    );

    always #5 clk = ~clk;

    // Stub adder: two real fp cases, otherwise integer sum plus rmode so routing is visible.
    always_comb begin
        add_result    = add_a + add_b + {29'd0, add_rmode};
        add_overflow  = 1'b0;
        add_underflow = (add_rmode == 3'd1);
        if (add_a == 32'h3F80_0000 && add_b == 32'h3F80_0000) begin
            add_result    = 32'h4000_0000;
            add_underflow = 1'b0;
        end else if (add_a == 32'h7F7F_FFFF && add_b == 32'h7F7F_FFFF) begin
            add_result    = 32'h7F80_0000;
            add_overflow  = 1'b1;
            add_underflow = 1'b0;
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a, b;
        logic [2:0]  rmode;
        logic [31:0] exp_result;
        logic        exp_ovf, exp_unf;
        logic [2:0]  exp_add_rmode;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] rm);
        req_a[32*i +: 32]   = a;
        req_b[32*i +: 32]   = b;
        req_rmode[3*i +: 3] = rm;
    endtask

    task automatic drain();
        rsp_ready = '1;
        for (int c = 0; c < 10 && busy; c++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1 check("drain_busy", 32'(busy), 32'd0);
        rsp_ready = '0;
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_vec(input vec_t v, input int n, input logic [N_REQ-1:0] clr);
        logic [N_REQ-1:0] oh;
        oh = '0;
        oh[v.id] = 1'b1;
        for (int i = 0; i < N_REQ; i++)
            if (i == v.id) set_lane(i, v.a, v.b, v.rmode);
            else set_lane(i, 32'hDEAD_BEEF, 32'h1234_5678, 3'd3);
        req_valid = oh;
        #1 check($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(oh));
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        check($sformatf("v%0d_add_a", n), add_a, v.a);
        check($sformatf("v%0d_add_b", n), add_b, v.b);
        check($sformatf("v%0d_add_rmode", n), 32'(add_rmode), 32'(v.exp_add_rmode));
        check($sformatf("v%0d_exec_rsp_valid", n), 32'(rsp_valid), 32'd0);
`ifdef FP_ADD_SCHED_STICKY_EN
        sticky_clr = clr;
`else
        if (clr != '0) check("clr_without_sticky", 32'(clr), 32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
`ifdef FP_ADD_SCHED_STICKY_EN
        sticky_clr = '0;
`endif
        #1;
        check($sformatf("v%0d_rsp_valid", n), 32'(rsp_valid), 32'(oh));
        check($sformatf("v%0d_rsp_result", n), rsp_result, v.exp_result);
        check($sformatf("v%0d_rsp_overflow", n), 32'(rsp_overflow), 32'(v.exp_ovf));
        check($sformatf("v%0d_rsp_underflow", n), 32'(rsp_underflow), 32'(v.exp_unf));
        rsp_ready = oh;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = '0;
        #1 check($sformatf("v%0d_busy_after", n), 32'(busy), 32'd0);
    endtask

    initial begin
        logic [N_REQ-1:0] grants[4];
        int               gcyc[4];
        int               ngrant, nrsp;
        logic [31:0]      held;

        vecs[0] = '{0, 32'h3F80_0000, 32'h3F80_0000, 3'd0, 32'h4000_0000, 1'b0, 1'b0, 3'd0};
        vecs[1] = '{1, 32'h0000_0010, 32'h0000_0020, 3'd3, 32'h0000_0033, 1'b0, 1'b0, 3'd3};
        vecs[2] = '{0, 32'h0000_0100, 32'h0000_0001, 3'd1, 32'h0000_0102, 1'b0, 1'b1, 3'd1};
        vecs[3] = '{1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'd0, 32'h7F80_0000, 1'b1, 1'b0, 3'd0};
        vecs[4] = '{1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 3'd7, 32'h7F80_0000, 1'b1, 1'b0, 3'd0};
        vecs[5] = '{0, 32'h0000_0010, 32'h0000_0020, 3'd5, 32'h0000_0030, 1'b0, 1'b0, 3'd0};
        vecs[6] = '{1, 32'h0000_0010, 32'h0000_0020, 3'd4, 32'h0000_0034, 1'b0, 1'b0, 3'd4};
        vecs[7] = '{0, 32'hFFFF_FFFF, 32'h0000_0002, 3'd2, 32'h0000_0003, 1'b0, 1'b0, 3'd2};

        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_rmode = '0;
`ifdef FP_ADD_SCHED_STICKY_EN
        sticky_clr = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_a", add_a, 32'd0);
        check("rst_add_rmode", 32'(add_rmode), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);

        // Both requesters held valid: alternating grants, 3-cycle issue interval.
        @(negedge clk);
        set_lane(0, 32'h1, 32'h2, 3'd0);
        set_lane(1, 32'h10, 32'h20, 3'd0);
        req_valid = 2'b11; rsp_ready = 2'b11;
        ngrant = 0; nrsp = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready != '0) begin
                grants[ngrant] = req_ready;
                gcyc[ngrant]   = c;
                ngrant++;
            end
            if (rsp_valid != '0) begin
                check($sformatf("rr_rsp_valid%0d", nrsp), 32'(rsp_valid),
                      (nrsp % 2 == 0) ? 32'd1 : 32'd2);
                check($sformatf("rr_rsp_result%0d", nrsp), rsp_result,
                      (nrsp % 2 == 0) ? 32'h3 : 32'h30);
                nrsp++;
            end
            if (ngrant == 4) break;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = '0;
        check("rr_grant_count", 32'(ngrant), 32'd4);
        check("rr_rsp_count", 32'(nrsp), 32'd3);
        for (int g = 0; g < ngrant; g++) begin
            check($sformatf("rr_grant%0d", g), 32'(grants[g]), (g % 2 == 0) ? 32'd1 : 32'd2);
            if (g > 0) check($sformatf("rr_interval%0d", g), 32'(gcyc[g] - gcyc[g-1]), 32'd3);
        end
        drain();

        // Owner 1 stalls its response while requester 0 waits.
        set_lane(1, 32'h100, 32'h200, 3'd3);
        set_lane(0, 32'h1, 32'h2, 3'd0);
        req_valid = 2'b10;
        #1 check("bp_grant1", 32'(req_ready), 32'd2);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        #1 check("bp_exec_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 2'b01;
        #1;
        check("bp_rsp_valid", 32'(rsp_valid), 32'd2);
        check("bp_rsp_result", rsp_result, 32'h303);
        held = rsp_result;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            check($sformatf("bp_hold_valid%0d", c), 32'(rsp_valid), 32'd2);
            check($sformatf("bp_hold_result%0d", c), rsp_result, held);
            check($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b10;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = '0;
        #1;
        check("bp_release_grant0", 32'(req_ready), 32'd1);
        check("bp_release_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        drain();

        // Reset asserted while the op is in EXEC.
        set_lane(0, 32'h5, 32'h6, 3'd2);
        req_valid = 2'b01;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1 check("rst_exec_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_exec_busy", 32'(busy), 32'd0);
        check("rst_exec_add_a", add_a, 32'd0);
        check("rst_exec_add_b", add_b, 32'd0);
        check("rst_exec_add_rmode", 32'(add_rmode), 32'd0);
        check("rst_exec_rsp_result", rsp_result, 32'd0);
        check("rst_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            #1 check($sformatf("rst_exec_no_rsp%0d", c), 32'(rsp_valid | {1'b0, busy}), 32'd0);
        end
        req_valid = 2'b11;
        #1 check("rst_exec_ptr0", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        drain();

        for (int n = 0; n < 8; n++) run_vec(vecs[n], n, '0);

`ifdef FP_ADD_SCHED_STICKY_EN
        #1;
        check("sticky_ovf_after_table", 32'(sticky_ovf), 32'd2);
        check("sticky_unf_after_table", 32'(sticky_unf), 32'd1);
        sticky_clr = 2'b11;
        @(posedge clk);
        @(negedge clk);
        sticky_clr = '0;
        #1 check("sticky_cleared", 32'(sticky_ovf | sticky_unf), 32'd0);
        run_vec(vecs[3], 10, '0);
        check("sticky_ovf_set", 32'(sticky_ovf), 32'd2);
        run_vec(vecs[3], 11, 2'b10);
        check("sticky_set_wins", 32'(sticky_ovf), 32'd2);
        sticky_clr = 2'b10;
        @(posedge clk);
        @(negedge clk);
        sticky_clr = '0;
        #1 check("sticky_lone_clear", 32'(sticky_ovf), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end
endmodule
